// File: rtl/edge_capture_if.sv
// Bus bundle for edge_capture: control/stimulus inputs and capture outputs.
// The master side drives clken/i/mode/mask/clr; the slave side (the DUT)
// returns lvl/pulse/flag/ovf/irq.
interface edge_capture_if #(
   parameter int WIDTH = 8
);
   logic               clken;
   logic [WIDTH-1:0]   i;
   logic [2*WIDTH-1:0] mode;
   logic [WIDTH-1:0]   mask;
   logic [WIDTH-1:0]   clr;
   logic [WIDTH-1:0]   lvl;
   logic [WIDTH-1:0]   pulse;
   logic [WIDTH-1:0]   flag;
   logic [WIDTH-1:0]   ovf;
   logic               irq;

   modport master (
      output clken, i, mode, mask, clr,
      input  lvl, pulse, flag, ovf, irq
   );

   modport slave (
      input  clken, i, mode, mask, clr,
      output lvl, pulse, flag, ovf, irq
   );
endinterface

// File: rtl/edge_capture.sv
// Multi-channel edge capture: per-channel synchronizer, glitch filter,
// mode-qualified edge detector, sticky event/overrun flags and a masked,
// registered interrupt. Everything advances only while clken is high.
module edge_capture #(
   parameter int WIDTH  = 8,
   parameter int SYNC   = 2,
   parameter int FILTER = 4
) (
   input logic          clk,
   input logic          rst_n,
   edge_capture_if.slave bus
);

   localparam int CW = (FILTER > 0) ? $clog2(FILTER + 1) : 1;

   logic [WIDTH-1:0] sync;     // synchronized channel inputs
   logic [WIDTH-1:0] lvl;      // filtered level
   logic [WIDTH-1:0] lvl_d;    // filtered level of the previous enabled cycle
   logic [WIDTH-1:0] hit;      // mode-qualified edge this cycle
   logic [WIDTH-1:0] pulse_q;
   logic [WIDTH-1:0] flag_q;
   logic [WIDTH-1:0] ovf_q;
   logic             irq_q;

   // ---------------------------------------------------------------- sync
   generate
      if (SYNC == 0) begin : g_nosync
         assign sync = bus.i;
      end else begin : g_sync
         logic [WIDTH-1:0] stage [SYNC];

         // Shift each channel through SYNC flops on enabled cycles.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               // NOTE: the stage array is a handful of flops, not a RAM, so it is
               // cleared on reset like any other state; sequential logic uses <=.
               for (int s = 0; s < SYNC; s++) stage[s] <= '0;
            end else if (bus.clken) begin
               stage[0] <= bus.i;
               for (int s = 1; s < SYNC; s++) stage[s] <= stage[s-1];
            end
         end

         assign sync = stage[SYNC-1];
      end
   endgenerate

   // -------------------------------------------------------------- filter
   generate
      if (FILTER == 0) begin : g_nofilter
         assign lvl = sync;
      end else begin : g_filter
         logic [CW-1:0]    cnt [WIDTH];
         logic [WIDTH-1:0] lvl_q;

         // Count consecutive enabled cycles that sync disagrees with lvl; adopt
         // the new level when the count would reach FILTER. For a 1-bit channel,
         // sync differing from both lvl and its previous value can only be the
         // first cycle of a new level, where the count is already 0, so the
         // equality test alone restarts the count on every glitch.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lvl_q <= '0;
               for (int n = 0; n < WIDTH; n++) cnt[n] <= '0;
            end else if (bus.clken) begin
               for (int n = 0; n < WIDTH; n++) begin
                  if (sync[n] == lvl_q[n]) begin
                     cnt[n] <= '0;
                  end else if (cnt[n] == CW'(FILTER - 1)) begin
                     lvl_q[n] <= sync[n];
                     cnt[n]   <= '0;
                  end else begin
                     cnt[n] <= cnt[n] + CW'(1);
                  end
               end
            end
         end

         assign lvl = lvl_q;
      end
   endgenerate

   // -------------------------------------------------------- edge qualify
   // Qualify lvl changes against the current per-channel mode.
   always_comb begin
      hit = '0;
      for (int n = 0; n < WIDTH; n++) begin
         hit[n] = (bus.mode[2*n]   &  lvl[n] & ~lvl_d[n])
                | (bus.mode[2*n+1] & ~lvl[n] &  lvl_d[n]);
      end
   end

   // --------------------------------------------------- pulse/flags/irq
   // Register the edge strobe and update the sticky flags; set beats clear
   // for flag, and a coinciding clear suppresses an overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_d   <= '0;
         pulse_q <= '0;
         flag_q  <= '0;
         ovf_q   <= '0;
         irq_q   <= 1'b0;
      end else if (bus.clken) begin
         lvl_d   <= lvl;
         pulse_q <= hit;
         flag_q  <= hit | (flag_q & ~bus.clr);
         ovf_q   <= (ovf_q & ~bus.clr) | (hit & flag_q & ~bus.clr);
         irq_q   <= |(flag_q & bus.mask);
      end else begin
         pulse_q <= '0;
      end
   end

   assign bus.lvl   = lvl;
   assign bus.pulse = pulse_q & {WIDTH{bus.clken}};
   assign bus.flag  = flag_q;
   assign bus.ovf   = ovf_q;
   assign bus.irq   = irq_q;

endmodule

// File: tb/tb_edge_capture.sv
// Directed bench for edge_capture (WIDTH=8, SYNC=2, FILTER=4): latency,
// glitch rejection, overrun, clear/edge collision, clock-enable freeze,
// mask/mode changes and reset mid-count.
module tb_edge_capture;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   edge_capture_if #(.WIDTH(8)) bus ();

   edge_capture #(.WIDTH(8), .SYNC(2), .FILTER(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle away from the edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic seen_p;
      logic seen_l;
      n_checks  = 0;
      n_errors  = 0;
      rst_n     = 1'b0;
      bus.clken = 1'b1;
      bus.i     = '0;
      bus.mode  = 16'h55DD;   // ch1 and ch3 both-edge, all others rising
      bus.mask  = 8'h01;
      bus.clr   = '0;

      // Reset state
      #12;
      check("rst_lvl",   bus.lvl,   0);
      check("rst_pulse", bus.pulse, 0);
      check("rst_flag",  bus.flag,  0);
      check("rst_ovf",   bus.ovf,   0);
      check("rst_irq",   bus.irq,   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(2);

      // Rising edge on ch0: pulse exactly 7 cycles later, irq one after flag
      bus.i[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("s1_pulse_k%0d", k), bus.pulse[0], (k == 7));
         if (k == 6) check("s1_lvl", bus.lvl[0], 1);
         if (k == 7) begin
            check("s1_flag", bus.flag[0], 1);
            check("s1_irq_early", bus.irq, 0);
         end
         if (k == 8) check("s1_irq", bus.irq, 1);
      end

      // Mask change reaches irq one cycle later
      bus.mask = 8'h00;
      check("mask_irq_hold", bus.irq, 1);
      tick();
      check("mask_irq_off", bus.irq, 0);

      // Mode change alone creates no edge and leaves flags alone
      bus.mode[1:0] = 2'b10;
      seen_p = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         seen_p |= bus.pulse[0];
      end
      check("mode_no_pulse", seen_p, 0);
      check("mode_flag", bus.flag[0], 1);
      bus.mode[1:0] = 2'b01;

      // 3-cycle glitch on ch1 (both-edge mode) is rejected
      bus.i[1] = 1'b1;
      tick(3);
      bus.i[1] = 1'b0;
      seen_p = 1'b0;
      seen_l = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         seen_p |= bus.pulse[1];
         seen_l |= bus.lvl[1];
      end
      check("glitch_pulse", seen_p, 0);
      check("glitch_lvl",   seen_l, 0);
      check("glitch_flag",  bus.flag[1], 0);

      // Two rising edges on ch2 without clear -> overrun; clear drops both
      bus.i[2] = 1'b1;
      tick(10);
      check("ovf_flag1", bus.flag[2], 1);
      check("ovf_ovf1",  bus.ovf[2],  0);
      bus.i[2] = 1'b0;
      tick(10);
      check("ovf_fall_ignored", bus.ovf[2], 0);
      bus.i[2] = 1'b1;
      tick(10);
      check("ovf_flag2", bus.flag[2], 1);
      check("ovf_ovf2",  bus.ovf[2],  1);
      bus.clr[2] = 1'b1;
      tick();
      bus.clr[2] = 1'b0;
      check("clr_flag", bus.flag[2], 0);
      check("clr_ovf",  bus.ovf[2],  0);

      // Clear coinciding with an edge on ch3: flag stays, no overrun
      bus.i[3] = 1'b1;
      tick(10);
      check("coll_pre_flag", bus.flag[3], 1);
      bus.i[3] = 1'b0;
      tick(6);
      bus.clr[3] = 1'b1;
      tick();
      bus.clr[3] = 1'b0;
      check("coll_pulse", bus.pulse[3], 1);
      check("coll_flag",  bus.flag[3],  1);
      check("coll_ovf",   bus.ovf[3],   0);

      // clken low for 10 cycles mid-filter on ch5
      bus.i[5] = 1'b1;
      tick(3);
      bus.clken = 1'b0;
      seen_p = 1'b0;
      seen_l = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         seen_p |= (|bus.pulse);
         seen_l |= bus.lvl[5];
      end
      check("frz_pulse", seen_p, 0);
      check("frz_lvl",   seen_l, 0);
      bus.clken = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("frz_resume_k%0d", k), bus.pulse[5], (k == 4));
      end

      // Reset mid-count on ch4, then release with inputs held high
      bus.i[4] = 1'b1;
      tick(4);
      rst_n = 1'b0;
      #1;
      check("mrst_lvl",   bus.lvl,   0);
      check("mrst_pulse", bus.pulse, 0);
      check("mrst_flag",  bus.flag,  0);
      check("mrst_ovf",   bus.ovf,   0);
      check("mrst_irq",   bus.irq,   0);
      tick(2);
      check("mrst_hold_lvl", bus.lvl, 0);
      rst_n = 1'b1;
      // ch0, ch2, ch4, ch5 are held high with rising mode: all fire together
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("rel_pulse_k%0d", k), bus.pulse, (k == 7) ? 8'h35 : 8'h00);
      end
      check("rel_flag", bus.flag, 8'h35);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/edge_capture.md
EDGE_CAPTURE -- requirements
Module: edge_capture

Interface
REQ-001 Parameter WIDTH, default 8, number of independent input channels (1..32).
REQ-002 Parameter SYNC, default 2, synchronizer flip-flop stages per channel (0 = input used directly, else 2..4).
REQ-003 Parameter FILTER, default 4, cycles an input must hold a new level before the filtered level changes (0 = no filter).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clken  input  1  clock enable; when low, all internal state holds and pulse outputs are 0.
REQ-007 i  input  WIDTH  asynchronous channel inputs.
REQ-008 mode  input  2*WIDTH  per-channel edge select, bits [2n+1:2n]: 00 off, 01 rising, 10 falling, 11 both.
REQ-009 mask  input  WIDTH  per-channel interrupt enable.
REQ-010 clr  input  WIDTH  write-one-to-clear strobe for flag and ovf, sampled when clken high.
REQ-011 lvl  output  WIDTH  filtered level of each channel.
REQ-012 pulse  output  WIDTH  one-cycle event strobe per channel.
REQ-013 flag  output  WIDTH  sticky event flag per channel.
REQ-014 ovf  output  WIDTH  sticky overrun flag per channel.
REQ-015 irq  output  1  interrupt request, OR of (flag & mask).

Function
REQ-016 Each channel shall pass through SYNC flip-flops, advancing only when clken is high.
REQ-017 With FILTER > 0, each channel shall keep a counter of width clog2(FILTER+1) that resets to 0 whenever the synchronized input equals lvl, or when it differs from the previous cycle's synchronized value.
REQ-018 The counter shall increment while the synchronized input differs from lvl, and lvl shall take the new value on the cycle the counter reaches FILTER, with the counter returning to 0.
REQ-019 A glitch shorter than FILTER enabled cycles shall never change lvl.
REQ-020 With FILTER = 0, lvl shall equal the last synchronized value.
REQ-021 An edge shall be a change of lvl between consecutive enabled cycles, qualified by mode: rising 0->1, falling 1->0, both either, off none.
REQ-022 pulse[n] shall be high for exactly the one clken-high cycle in which the qualified edge is registered, with no combinational path from i.
REQ-023 Latency from a stable input change to pulse shall be SYNC + FILTER + 1 enabled cycles.
REQ-024 flag[n] shall set on a qualified edge and clear on clr[n].
REQ-025 When a qualified edge and clr[n] coincide, flag[n] shall remain set (set wins).
REQ-026 ovf[n] shall set on a qualified edge while flag[n] is already 1 and clr[n] is 0, and shall clear on clr[n].
REQ-027 When a qualified edge and clr[n] coincide, ovf[n] shall not set.
REQ-028 irq shall be registered, equal to the previous cycle's OR(flag & mask), and shall respond to mask changes one cycle later.
REQ-029 A change to mode shall affect only edges registered after the change, and shall never generate an edge by itself.
REQ-030 A mode change shall not alter flag or ovf.
REQ-031 Channels shall be fully independent; simultaneous events on any channels shall all be captured.

Reset
REQ-032 While rst_n is low, sync stages, lvl, counters, pulse, flag, ovf and irq shall be 0, asynchronously.
REQ-033 After reset deassertion, an input held at 1 shall be seen as a 0->1 transition and generate a rising edge after the REQ-023 latency.
REQ-034 Reset asserted mid-filter shall discard the partial count.

Verification
REQ-035 Scenario: WIDTH=8, SYNC=2, FILTER=4, mode=01, i[0] 0->1 held -> pulse[0] high exactly 7 cycles later for one cycle, flag[0]=1, irq=1 one cycle after flag with mask[0]=1.
REQ-036 Scenario: i[1] high-going glitch of 3 cycles, mode=11 -> lvl[1] stays 0, no pulse, flag[1]=0.
REQ-037 Scenario: two rising edges on i[2] with no clr between -> flag[2]=1, ovf[2]=1; clr[2] pulse -> both 0 next cycle.
REQ-038 Scenario: clr[3] asserted in the same cycle as the pulse[3] edge -> flag[3]=1, ovf[3]=0.
REQ-039 Scenario: clken low for 10 cycles during an input change -> state frozen, pulse 0; resumes with latency counted in enabled cycles only.
REQ-040 Scenario: rst_n low mid-count and then released with i[4]=1, mode=01 -> all outputs 0 during reset, one pulse[4] at 7 enabled cycles after release.
